nv_nvdla_csb_master_falcon2csb_fifo_wr_ctrl: RTL and testbench

//  - Write-side controller of the falcon2csb async FIFO; feeds the Gray-coded write pointer consumed by the read domain.
//  - Accepts falcon requests and drives the FIFO RAM write port.
//  - Maintains the binary and Gray write pointers.
//  - Synchronizes the read domain's Gray pointer and derives full, busy and occupancy.

---
 rtl/nv_nvdla_csb_master_falcon2csb_fifo_wr_ctrl_pkg.sv | 24 ++
 rtl/nv_nvdla_csb_master_falcon2csb_fifo_ptr_sync.sv | 24 ++
 rtl/nv_nvdla_csb_master_falcon2csb_fifo_wr_ctrl.sv | 73 +++++++
 tb/tb_nv_nvdla_csb_master_falcon2csb_fifo_wr_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_csb_master_falcon2csb_fifo_wr_ctrl_pkg.sv
// Shared constants and pointer-code helpers for the falcon2csb async FIFO controllers.
package nv_nvdla_csb_master_falcon2csb_fifo_wr_ctrl_pkg;

  localparam int FALCON2CSB_FIFO_ADDR_W = 2;
  localparam int FALCON2CSB_FIFO_DATA_W = 50;

  // Helpers work on a wide container; callers zero-extend in and truncate out.
  localparam int PTR_MAX_W = 16;
  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/nv_nvdla_csb_master_falcon2csb_fifo_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into this clock domain.
module nv_nvdla_csb_master_falcon2csb_fifo_ptr_sync #(
  parameter int WIDTH    = 3,
  parameter int SYNC_STG = 2
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [SYNC_STG-1:0][WIDTH-1:0] r_stg;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_stg <= '0;
    end else begin
      r_stg <= {r_stg[SYNC_STG-2:0], i_d};
    end
  end

  assign o_q = r_stg[SYNC_STG-1];

endmodule

// File: rtl/nv_nvdla_csb_master_falcon2csb_fifo_wr_ctrl.sv
// Write-side controller of the falcon2csb async FIFO: RAM write port, write pointers,
// read-pointer synchronization, full/busy and occupancy. ADDR_W must be at least 2.
module nv_nvdla_csb_master_falcon2csb_fifo_wr_ctrl
  import nv_nvdla_csb_master_falcon2csb_fifo_wr_ctrl_pkg::*;
#(
  parameter int ADDR_W   = FALCON2CSB_FIFO_ADDR_W,
  parameter int DATA_W   = FALCON2CSB_FIFO_DATA_W,
  parameter int SYNC_STG = 2
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_pd,
  output logic              wr_busy,
  input  logic [ADDR_W:0]   rd_gray_async,
  output logic [ADDR_W:0]   wr_gray,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_wa,
  output logic [DATA_W-1:0] ram_wd,
  output logic [ADDR_W:0]   wr_count
);

  localparam int PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] r_wr_bin;
  logic [PTR_W-1:0] r_wr_gray;
  logic [PTR_W-1:0] w_next_bin;
  logic [PTR_W-1:0] w_next_gray;
  logic [PTR_W-1:0] w_rd_gray_s;
  logic [PTR_W-1:0] w_rd_bin_s;
  logic [PTR_W-1:0] w_full_tgt;
  logic             w_full;
  logic             w_accept;

  nv_nvdla_csb_master_falcon2csb_fifo_ptr_sync #(
    .WIDTH    (PTR_W),
    .SYNC_STG (SYNC_STG)
  ) u_rd_ptr_sync (
    .clk    (clk),
    .reset_ (reset_),
    .i_d    (rd_gray_async),
    .o_q    (w_rd_gray_s)
  );

  assign w_rd_bin_s  = PTR_W'(gray2bin(ptr_t'(w_rd_gray_s)));
  assign w_next_bin  = r_wr_bin + PTR_W'(1);
  assign w_next_gray = PTR_W'(bin2gray(ptr_t'(w_next_bin)));

  // Full when the write pointer is exactly one lap ahead of the synchronized read pointer.
  assign w_full_tgt = {~w_rd_gray_s[ADDR_W:ADDR_W-1], w_rd_gray_s[ADDR_W-2:0]};
  assign w_full     = (r_wr_gray == w_full_tgt);

  // Gating with reset_ keeps the RAM from being written while the FIFO is held in reset.
  assign w_accept = wr_req & ~w_full & reset_;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_wr_bin  <= '0;
      r_wr_gray <= '0;
    end else if (w_accept) begin
      r_wr_bin  <= w_next_bin;
      r_wr_gray <= w_next_gray;
    end
  end

  assign wr_busy  = w_full;
  assign wr_gray  = r_wr_gray;
  assign ram_we   = w_accept;
  assign ram_wa   = r_wr_bin[ADDR_W-1:0];
  assign ram_wd   = wr_pd;
  assign wr_count = r_wr_bin - w_rd_bin_s;

endmodule

// File: tb/tb_nv_nvdla_csb_master_falcon2csb_fifo_wr_ctrl.sv
// Self-checking bench for the falcon2csb FIFO write controller (ADDR_W=2, SYNC_STG=2).
module tb_nv_nvdla_csb_master_falcon2csb_fifo_wr_ctrl;

  localparam int ADDR_W   = 2;
  localparam int DATA_W   = 50;
  localparam int SYNC_STG = 2;
  localparam int DEPTH    = 4;

  logic              clk = 1'b0;
  logic              reset_;
  logic              wr_req;
  logic [DATA_W-1:0] wr_pd;
  logic              wr_busy;
  logic [ADDR_W:0]   rd_gray_async;
  logic [ADDR_W:0]   wr_gray;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_wa;
  logic [DATA_W-1:0] ram_wd;
  logic [ADDR_W:0]   wr_count;

  int checks = 0;
  int errors = 0;

  // Reference model: unbounded write/read counts and a delay line for the read pointer.
  int m_wp;
  int m_rd;
  int m_rds;
  int sync_q[$];

  nv_nvdla_csb_master_falcon2csb_fifo_wr_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .SYNC_STG (SYNC_STG)
  ) dut (
    .clk           (clk),
    .reset_        (reset_),
    .wr_req        (wr_req),
    .wr_pd         (wr_pd),
    .wr_busy       (wr_busy),
    .rd_gray_async (rd_gray_async),
    .wr_gray       (wr_gray),
    .ram_we        (ram_we),
    .ram_wa        (ram_wa),
    .ram_wd        (ram_wd),
    .wr_count      (wr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [ADDR_W:0] gray_of(input int n);
    int m;
    m = n % (2 * DEPTH);
    return (ADDR_W+1)'(m ^ (m >> 1));
  endfunction

  function automatic int m_count();
    return (m_wp - m_rds) % (2 * DEPTH);
  endfunction

  function automatic bit m_busy();
    return m_count() == DEPTH;
  endfunction

  task automatic model_reset();
    m_wp  = 0;
    m_rd  = 0;
    m_rds = 0;
    sync_q.delete();
  endtask

  task automatic drive(input bit req, input logic [DATA_W-1:0] pd, input int rd);
    @(negedge clk);
    wr_req        = req;
    wr_pd         = pd;
    m_rd          = rd;
    rd_gray_async = gray_of(rd);
    #1;
  endtask

  task automatic tick();
    bit acc;
    acc = wr_req && !m_busy();
    @(posedge clk);
    if (acc) m_wp++;
    sync_q.push_back(m_rd);
    if (sync_q.size() > SYNC_STG) void'(sync_q.pop_front());
    if (sync_q.size() == SYNC_STG) m_rds = sync_q[0];
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_        = 1'b0;
    wr_req        = 1'b0;
    rd_gray_async = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_ = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_        = 1'b0;
    wr_req        = 1'b1;
    wr_pd         = '1;
    rd_gray_async = '0;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %0b want 0", ram_we); end
    checks++; if (wr_gray !== 3'b000) begin errors++; $display("FAIL reset_wr_gray: got %b want 000", wr_gray); end
    checks++; if (wr_busy !== 1'b0) begin errors++; $display("FAIL reset_wr_busy: got %0b want 0", wr_busy); end
    checks++; if (wr_count !== 3'd0) begin errors++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
    @(posedge clk); #1;
    checks++; if (ram_we !== 1'b0 || wr_gray !== 3'b000) begin
      errors++; $display("FAIL reset_hold: ram_we=%0b wr_gray=%b want 0/000", ram_we, wr_gray);
    end
    @(negedge clk);
    wr_req = 1'b0;
    reset_ = 1'b1;
    model_reset();
  endtask

  task automatic test_fill();
    int writes;
    writes = 0;
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, DATA_W'(i), 0);
      checks++; if (ram_we !== !m_busy()) begin errors++; $display("FAIL fill_we[%0d]: got %0b want %0b", i, ram_we, !m_busy()); end
      if (!m_busy()) begin
        writes++;
        checks++; if (ram_wa !== ADDR_W'(i - 1)) begin errors++; $display("FAIL fill_wa[%0d]: got %0d want %0d", i, ram_wa, i - 1); end
        checks++; if (ram_wd !== DATA_W'(i)) begin errors++; $display("FAIL fill_wd[%0d]: got %0h want %0h", i, ram_wd, i); end
      end
      checks++; if (wr_gray !== gray_of(m_wp)) begin errors++; $display("FAIL fill_gray[%0d]: got %b want %b", i, wr_gray, gray_of(m_wp)); end
      checks++; if (wr_busy !== m_busy()) begin errors++; $display("FAIL fill_busy[%0d]: got %0b want %0b", i, wr_busy, m_busy()); end
      checks++; if (wr_count !== 3'(m_count())) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, wr_count, m_count()); end
      tick();
    end
    drive(1'b0, '0, 0);
    checks++; if (writes != DEPTH) begin errors++; $display("FAIL fill_writes: got %0d want %0d", writes, DEPTH); end
    checks++; if (wr_gray !== 3'b110) begin errors++; $display("FAIL fill_final_gray: got %b want 110", wr_gray); end
    checks++; if (wr_count !== 3'd4 || wr_busy !== 1'b1) begin
      errors++; $display("FAIL fill_final: count=%0d busy=%0b want 4/1", wr_count, wr_busy);
    end
    tick();
  endtask

  task automatic test_drain();
    for (int k = 0; k < SYNC_STG; k++) begin
      drive(1'b1, DATA_W'(100 + k), 1);
      checks++; if (wr_busy !== 1'b1 || ram_we !== 1'b0) begin
        errors++; $display("FAIL drain_hold[%0d]: busy=%0b we=%0b want 1/0", k, wr_busy, ram_we);
      end
      tick();
    end
    drive(1'b1, DATA_W'('h77), 1);
    checks++; if (wr_busy !== 1'b0) begin errors++; $display("FAIL drain_release: busy got %0b want 0", wr_busy); end
    checks++; if (ram_we !== 1'b1 || ram_wa !== 2'd0) begin
      errors++; $display("FAIL drain_write: we=%0b wa=%0d want 1/0", ram_we, ram_wa);
    end
    tick();
    drive(1'b0, '0, 1);
    checks++; if (wr_gray !== 3'b111) begin errors++; $display("FAIL drain_gray: got %b want 111", wr_gray); end
    checks++; if (wr_count !== 3'd4 || wr_busy !== 1'b1) begin
      errors++; $display("FAIL drain_full: count=%0d busy=%0b want 4/1", wr_count, wr_busy);
    end
    tick();
  endtask

  task automatic test_wrap();
    int exp_seq[9];
    int acc;
    int cyc;
    int rd;
    bit req;
    bit exp_we;
    logic [DATA_W-1:0] pd;
    logic [ADDR_W:0] prev;
    exp_seq = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
    apply_reset();
    acc  = 0;
    cyc  = 0;
    prev = '0;
    while (acc < 8 && cyc < 200) begin
      rd = m_rd;
      if (m_rd < m_wp && $urandom_range(0, 2) != 0) rd = m_rd + 1;
      req = ($urandom_range(0, 3) != 0);
      pd  = DATA_W'({$urandom, $urandom});
      drive(req, pd, rd);
      exp_we = req && !m_busy();
      checks++; if (ram_we !== exp_we) begin errors++; $display("FAIL wrap_we[%0d]: got %0b want %0b", cyc, ram_we, exp_we); end
      if (exp_we) begin
        checks++; if (ram_wa !== ADDR_W'(m_wp % DEPTH) || ram_wd !== pd) begin
          errors++; $display("FAIL wrap_wr[%0d]: wa=%0d wd=%0h want %0d/%0h", cyc, ram_wa, ram_wd, m_wp % DEPTH, pd);
        end
      end
      checks++; if (wr_busy !== m_busy() || wr_count !== 3'(m_count())) begin
        errors++; $display("FAIL wrap_flags[%0d]: busy=%0b count=%0d want %0b/%0d", cyc, wr_busy, wr_count, m_busy(), m_count());
      end
      tick();
      cyc++;
      if (exp_we) begin
        acc++;
        #1;
        checks++; if (wr_gray !== 3'(exp_seq[acc])) begin errors++; $display("FAIL wrap_gray[%0d]: got %b want %b", acc, wr_gray, 3'(exp_seq[acc])); end
        checks++; if ($countones(wr_gray ^ prev) != 1) begin errors++; $display("FAIL wrap_onebit[%0d]: %b -> %b", acc, prev, wr_gray); end
        prev = wr_gray;
      end
    end
    checks++; if (acc != 8) begin errors++; $display("FAIL wrap_timeout: accepts got %0d want 8", acc); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DATA_W'(10 + i), 0);
      tick();
    end
    drive(1'b1, DATA_W'('h55), 1);
    checks++; if (wr_count !== 3'd3 || ram_we !== 1'b1 || wr_busy !== 1'b0) begin
      errors++; $display("FAIL simul_pre: count=%0d we=%0b busy=%0b want 3/1/0", wr_count, ram_we, wr_busy);
    end
    tick();
    drive(1'b0, '0, 1);
    checks++; if (wr_count !== 3'd4 || wr_busy !== m_busy()) begin
      errors++; $display("FAIL simul_mid: count=%0d busy=%0b want 4/%0b", wr_count, wr_busy, m_busy());
    end
    tick();
    drive(1'b0, '0, 1);
    checks++; if (wr_count !== 3'd3 || wr_busy !== 1'b0) begin
      errors++; $display("FAIL simul_post: count=%0d busy=%0b want 3/0", wr_count, wr_busy);
    end
    tick();
  endtask

  task automatic test_midop_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DATA_W'(20 + i), 0);
      tick();
    end
    drive(1'b0, '0, 0);
    checks++; if (wr_gray !== 3'b010 || wr_count !== 3'd3) begin
      errors++; $display("FAIL midrst_pre: gray=%b count=%0d want 010/3", wr_gray, wr_count);
    end
    @(negedge clk);
    wr_req = 1'b1;
    reset_ = 1'b0;
    #1;
    checks++; if (wr_gray !== 3'b000 || wr_count !== 3'd0) begin
      errors++; $display("FAIL midrst_clear: gray=%b count=%0d want 000/0", wr_gray, wr_count);
    end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL midrst_we: got %0b want 0", ram_we); end
    @(posedge clk); #1;
    checks++; if (ram_we !== 1'b0 || wr_gray !== 3'b000) begin
      errors++; $display("FAIL midrst_hold: we=%0b gray=%b want 0/000", ram_we, wr_gray);
    end
    @(negedge clk);
    reset_ = 1'b1;
    wr_req = 1'b0;
    model_reset();
    drive(1'b1, DATA_W'('habc), 0);
    checks++; if (ram_we !== 1'b1 || ram_wa !== 2'd0 || ram_wd !== DATA_W'('habc)) begin
      errors++; $display("FAIL midrst_first: we=%0b wa=%0d wd=%0h want 1/0/abc", ram_we, ram_wa, ram_wd);
    end
    tick();
    drive(1'b0, '0, 0);
    checks++; if (wr_gray !== 3'b001 || wr_count !== 3'd1) begin
      errors++; $display("FAIL midrst_after: gray=%b count=%0d want 001/1", wr_gray, wr_count);
    end
    tick();
  endtask

  initial begin
    reset_        = 1'b0;
    wr_req        = 1'b0;
    wr_pd         = '0;
    rd_gray_async = '0;
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_midop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
